data_mem_access_unit: RTL and testbench

Memory-stage consumer of the control unit's `mem_read`/`mem_write` encodings. Converts byte, halfword and word loads and stores at any byte address into word-aligned bus beats with byte enables. Splits accesses that cross a word boundary into two beats, and sign- or zero-extends load results. Stalls the pipeline through `busywait` until the access completes; sits between the EX/MEM pipeline register and the data memory/cache.

---
 rtl/data_mem_access_unit_pkg.sv | 30 +++
 rtl/mem_load_extend.sv | 37 +++
 rtl/data_mem_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_access_unit_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_access_unit_pkg
//   Shared definitions for the memory-stage access unit:
//   - load funct3 encodings (LD_*), as carried on mem_read[2:0]
//   - store funct3[1:0] encodings (ST_*), as carried on mem_write[1:0]
//   - the access FSM state encoding
// ----------------------------------------------------------------------------
package data_mem_access_unit_pkg;

  // Load funct3 encodings.
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  // Store funct3[1:0] encodings. Loads share the same size coding in
  // funct3[1:0], so these double as the access-size code for both.
  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_load_extend.sv
// ----------------------------------------------------------------------------
// mem_load_extend
//   Combinational load-result extractor. Shifts the 64-bit two-word read view
//   down by the byte offset and sign- or zero-extends according to funct3.
//   Ports:
//     rdata64 in  64 : {high beat word, low beat word}
//     off     in   2 : byte offset of the access within the low word
//     funct3  in   3 : load funct3; undefined codes return the full word
//     result  out 32 : extended load result
// ----------------------------------------------------------------------------
module mem_load_extend
  import data_mem_access_unit_pkg::*;
(
  input  logic [63:0] rdata64,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Only the low 32 bits of the shifted view can ever be needed.
  assign shifted = 32'(rdata64 >> {off, 3'b000});

  always_comb begin
    result = shifted;
    case (funct3)
      LD_B:    result = {{24{shifted[7]}},  shifted[7:0]};
      LD_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      LD_BU:   result = {24'h0, shifted[7:0]};
      LD_HU:   result = {16'h0, shifted[15:0]};
      LD_W:    result = shifted;
      default: result = shifted;  // 011/110/111 behave as LW
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// ----------------------------------------------------------------------------
// data_mem_access_unit
//   Memory-stage access unit between the EX/MEM register and data memory.
//   Turns byte/half/word loads and stores at any byte address into one or two
//   word-aligned bus beats with byte enables, extends load results, and holds
//   the pipeline with busywait until the access completes.
//   Ports:
//     clk, reset (async, active-low)
//     mem_read[3:0]   : [3] load request, [2:0] funct3
//     mem_write[2:0]  : [2] store request, [1:0] funct3[1:0]
//     address, store_data : request address and right-justified store data
//     load_data       : registered, extended load result
//     busywait        : pipeline stall request
//     bus_read/bus_write/bus_addr/bus_writedata/bus_byteen : registered beat
//     bus_readdata/bus_ready : beat response (ready is a one-cycle ack)
// ----------------------------------------------------------------------------
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        busywait,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_readdata,
  input  logic        bus_ready
);

  // --------------------------------------------------------------------------
  // Request decode (used only in IDLE when the request is latched)
  // --------------------------------------------------------------------------
  logic        req;
  logic        req_is_load;
  logic [2:0]  req_f3;
  logic [1:0]  req_off;
  logic        req_split;
  logic [3:0]  req_base;
  logic [7:0]  req_mask8;
  logic [63:0] req_wdata64;
  logic [31:0] req_addr1;

  assign req         = mem_read[3] | mem_write[2];
  assign req_is_load = mem_read[3];  // a load wins over a simultaneous store
  assign req_f3      = req_is_load ? mem_read[2:0] : {1'b0, mem_write[1:0]};
  assign req_off     = address[1:0];
  assign req_addr1   = {address[31:2], 2'b00};

  // funct3[1:0] is the size code for both loads and stores; 11 acts as word.
  assign req_split = ((req_f3[1:0] == ST_H) && (req_off == 2'd3)) ||
                     (req_f3[1] && (req_off != 2'd0));

  always_comb begin
    req_base = 4'b1111;
    case (req_f3[1:0])
      ST_B:    req_base = 4'b0001;
      ST_H:    req_base = 4'b0011;
      ST_W:    req_base = 4'b1111;
      default: req_base = 4'b1111;
    endcase
  end

  // Eight-lane view spanning the two candidate beats.
  assign req_mask8   = {4'b0000, req_base} << req_off;
  assign req_wdata64 = {32'h0, store_data} << {req_off, 3'b000};

  // --------------------------------------------------------------------------
  // Latched request and FSM state
  // --------------------------------------------------------------------------
  state_t      state_reg;
  logic        is_load_reg;
  logic [2:0]  f3_reg;
  logic [1:0]  off_reg;
  logic        split_reg;
  logic [31:0] addr2_reg;
  logic [3:0]  mask_hi_reg;
  logic [31:0] wdata_hi_reg;
  logic [31:0] rdata_lo_reg;

  logic        bus_read_reg;
  logic        bus_write_reg;
  logic [31:0] bus_addr_reg;
  logic [31:0] bus_writedata_reg;
  logic [3:0]  bus_byteen_reg;
  logic [31:0] load_data_reg;

  // In BEAT2 the low word was captured earlier; in BEAT1 (unsplit) the whole
  // access lies in the word arriving now.
  logic [63:0] ext_rdata64;
  logic [31:0] ext_result;

  assign ext_rdata64 = (state_reg == BEAT2) ? {bus_readdata, rdata_lo_reg}
                                            : {32'h0, bus_readdata};

  mem_load_extend u_load_extend (
    .rdata64 (ext_rdata64),
    .off     (off_reg),
    .funct3  (f3_reg),
    .result  (ext_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      is_load_reg       <= 1'b0;
      f3_reg            <= 3'b000;
      off_reg           <= 2'b00;
      split_reg         <= 1'b0;
      addr2_reg         <= 32'h0;
      mask_hi_reg       <= 4'h0;
      wdata_hi_reg      <= 32'h0;
      rdata_lo_reg      <= 32'h0;
      bus_read_reg      <= 1'b0;
      bus_write_reg     <= 1'b0;
      bus_addr_reg      <= 32'h0;
      bus_writedata_reg <= 32'h0;
      bus_byteen_reg    <= 4'h0;
      load_data_reg     <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            is_load_reg       <= req_is_load;
            f3_reg            <= req_f3;
            off_reg           <= req_off;
            split_reg         <= req_split;
            addr2_reg         <= req_addr1 + 32'd4;  // wraps modulo 2^32
            mask_hi_reg       <= req_is_load ? 4'h0  : req_mask8[7:4];
            wdata_hi_reg      <= req_is_load ? 32'h0 : req_wdata64[63:32];
            // First beat is launched straight from the latch cycle so the
            // bus outputs are registered and valid throughout BEAT1.
            bus_read_reg      <= req_is_load;
            bus_write_reg     <= ~req_is_load;
            bus_addr_reg      <= req_addr1;
            bus_byteen_reg    <= req_is_load ? 4'h0  : req_mask8[3:0];
            bus_writedata_reg <= req_is_load ? 32'h0 : req_wdata64[31:0];
            state_reg         <= BEAT1;
          end
        end

        BEAT1: begin
          if (bus_ready) begin
            if (split_reg) begin
              rdata_lo_reg      <= bus_readdata;
              bus_addr_reg      <= addr2_reg;
              bus_byteen_reg    <= mask_hi_reg;
              bus_writedata_reg <= wdata_hi_reg;
              state_reg         <= BEAT2;
            end else begin
              if (is_load_reg) load_data_reg <= ext_result;
              bus_read_reg      <= 1'b0;
              bus_write_reg     <= 1'b0;
              bus_addr_reg      <= 32'h0;
              bus_byteen_reg    <= 4'h0;
              bus_writedata_reg <= 32'h0;
              state_reg         <= DONE;
            end
          end
        end

        BEAT2: begin
          if (bus_ready) begin
            if (is_load_reg) load_data_reg <= ext_result;
            bus_read_reg      <= 1'b0;
            bus_write_reg     <= 1'b0;
            bus_addr_reg      <= 32'h0;
            bus_byteen_reg    <= 4'h0;
            bus_writedata_reg <= 32'h0;
            state_reg         <= DONE;
          end
        end

        // The pipeline advances on the edge leaving DONE, so the finished
        // request is gone by the time IDLE looks again.
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    busywait = 1'b0;
    case (state_reg)
      IDLE:    busywait = req;
      BEAT1:   busywait = 1'b1;
      BEAT2:   busywait = 1'b1;
      DONE:    busywait = 1'b0;
      default: busywait = 1'b0;
    endcase
  end

  assign load_data     = load_data_reg;
  assign bus_read      = bus_read_reg;
  assign bus_write     = bus_write_reg;
  assign bus_addr      = bus_addr_reg;
  assign bus_writedata = bus_writedata_reg;
  assign bus_byteen    = bus_byteen_reg;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_data_mem_access_unit
//   Directed bench: a word memory model with programmable wait states answers
//   the bus; each scenario task drives accesses and checks beats, stall
//   length and load results against hand-computed values.
// ----------------------------------------------------------------------------
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        busywait;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_readdata = 32'h0;
  logic        bus_ready = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  data_mem_access_unit dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .address       (address),
    .store_data    (store_data),
    .load_data     (load_data),
    .busywait      (busywait),
    .bus_read      (bus_read),
    .bus_write     (bus_write),
    .bus_addr      (bus_addr),
    .bus_writedata (bus_writedata),
    .bus_byteen    (bus_byteen),
    .bus_readdata  (bus_readdata),
    .bus_ready     (bus_ready)
  );

  // --------------------------------------------------------------------------
  // Memory model and beat log
  // --------------------------------------------------------------------------
  logic [31:0] mem [logic [31:0]];
  int          wait_cycles = 0;
  bit          hold_ready  = 1'b0;
  int          wcnt        = 0;

  logic [31:0] b_addr [4];
  logic [31:0] b_wd   [4];
  logic [3:0]  b_be   [4];
  logic        b_we   [4];
  int          nbeats = 0;
  logic [31:0] wr_word;

  // Responder: decides at the falling edge whether to ack the current beat.
  always @(negedge clk) begin
    if (!hold_ready && (bus_read || bus_write)) begin
      if (wcnt >= wait_cycles) begin
        bus_ready    = 1'b1;
        bus_readdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
        wcnt         = 0;
      end else begin
        bus_ready    = 1'b0;
        bus_readdata = 32'h0;
        wcnt++;
      end
    end else begin
      bus_ready    = 1'b0;
      bus_readdata = 32'h0;
      wcnt         = 0;
    end
  end

  // Log each acknowledged beat and apply writes under the byte enables.
  always @(posedge clk) begin
    if (reset && bus_ready && (bus_read || bus_write)) begin
      if (nbeats < 4) begin
        b_addr[nbeats] = bus_addr;
        b_wd[nbeats]   = bus_writedata;
        b_be[nbeats]   = bus_byteen;
        b_we[nbeats]   = bus_write;
      end
      nbeats++;
      if (bus_write) begin
        wr_word = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (bus_byteen[b]) wr_word[8*b +: 8] = bus_writedata[8*b +: 8];
        mem[bus_addr] = wr_word;
      end
    end
  end

  // One access: present the request at a falling edge, count stall cycles
  // (request cycle included), sample load_data in DONE, drop the request.
  task automatic run_access(input logic [3:0] mr, input logic [2:0] mw,
                            input logic [31:0] addr, input logic [31:0] sd,
                            output int busy, output logic [31:0] ld);
    for (int i = 0; i < 4; i++) begin
      b_addr[i] = 'x; b_wd[i] = 'x; b_be[i] = 'x; b_we[i] = 'x;
    end
    nbeats = 0;
    @(negedge clk);
    mem_read   = mr;
    mem_write  = mw;
    address    = addr;
    store_data = sd;
    #1;
    busy = busywait ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!busywait) break;
      busy++;
    end
    if (busywait) busy = -1;  // timed out; the caller's stall check fails
    ld = load_data;
    mem_read  = 4'b0;
    mem_write = 3'b0;
    $display("[TB] access rd=%b wr=%b addr=%h sd=%h beats=%0d busy=%0d load_data=%h",
             mr, mw, addr, sd, nbeats, busy, ld);
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; mem_read = 4'b0; mem_write = 3'b0;
    address = 32'h0; store_data = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({bus_read, bus_write, bus_addr, bus_byteen, bus_writedata, load_data, busywait} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h be=%b wd=%h ld=%h busy=%b expected all zero",
               bus_read, bus_write, bus_addr, bus_byteen, bus_writedata, load_data, busywait);
    end
    mem_read = 4'b1010;
    #1;
    tests_run++;
    if (busywait !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_busy_idle_rule: got %b expected 1", busywait);
    end
    mem_read = 4'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_aligned_lw();
    int busy; logic [31:0] ld;
    mem[32'h100] = 32'hDEADBEEF;
    run_access(4'b1010, 3'b000, 32'h100, 32'h0, busy, ld);
    tests_run++;
    if (ld !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL lw_data: got %h expected deadbeef", ld);
    end
    tests_run++;
    if (busy !== 2) begin
      tests_failed++; $display("FAIL lw_busy: got %0d expected 2", busy);
    end
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 32'h100 || b_we[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_beat: beats=%0d addr=%h we=%b expected 1 beat read at 00000100",
               nbeats, b_addr[0], b_we[0]);
    end
  endtask

  task automatic test_byte_half_loads();
    int busy; logic [31:0] ld;
    mem[32'h200] = 32'h80FF1234;
    run_access(4'b1000, 3'b000, 32'h203, 32'h0, busy, ld);  // LB
    tests_run++;
    if (ld !== 32'hFFFFFF80 || busy !== 2) begin
      tests_failed++; $display("FAIL lb_off3: got %h busy %0d expected ffffff80 busy 2", ld, busy);
    end
    run_access(4'b1100, 3'b000, 32'h203, 32'h0, busy, ld);  // LBU
    tests_run++;
    if (ld !== 32'h00000080) begin
      tests_failed++; $display("FAIL lbu_off3: got %h expected 00000080", ld);
    end
    run_access(4'b1001, 3'b000, 32'h202, 32'h0, busy, ld);  // LH
    tests_run++;
    if (ld !== 32'hFFFF80FF) begin
      tests_failed++; $display("FAIL lh_off2: got %h expected ffff80ff", ld);
    end
    run_access(4'b1101, 3'b000, 32'h202, 32'h0, busy, ld);  // LHU
    tests_run++;
    if (ld !== 32'h000080FF) begin
      tests_failed++; $display("FAIL lhu_off2: got %h expected 000080ff", ld);
    end
    run_access(4'b1011, 3'b000, 32'h200, 32'h0, busy, ld);  // funct3 011 as LW
    tests_run++;
    if (ld !== 32'h80FF1234) begin
      tests_failed++; $display("FAIL undef_f3_lw: got %h expected 80ff1234", ld);
    end
  endtask

  task automatic test_small_stores();
    int busy; logic [31:0] ld;
    run_access(4'b0000, 3'b100, 32'h301, 32'h123456A5, busy, ld);  // SB
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 32'h300 || b_be[0] !== 4'b0010 ||
        b_wd[0] !== 32'h3456A500 || b_we[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_off1: beats=%0d addr=%h be=%b wd=%h expected 1 write 00000300 0010 3456a500",
               nbeats, b_addr[0], b_be[0], b_wd[0]);
    end
    run_access(4'b0000, 3'b101, 32'h302, 32'h1234BEEF, busy, ld);  // SH
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 32'h300 || b_be[0] !== 4'b1100 ||
        b_wd[0] !== 32'hBEEF0000 || busy !== 2) begin
      tests_failed++;
      $display("FAIL sh_off2: beats=%0d addr=%h be=%b wd=%h busy=%0d expected 1 write 00000300 1100 beef0000 busy 2",
               nbeats, b_addr[0], b_be[0], b_wd[0], busy);
    end
    tests_run++;
    if (ld !== 32'h80FF1234) begin
      tests_failed++; $display("FAIL load_data_hold: got %h expected 80ff1234", ld);
    end
  endtask

  task automatic test_split_sw();
    int busy; logic [31:0] ld;
    run_access(4'b0000, 3'b110, 32'h102, 32'hAABBCCDD, busy, ld);
    tests_run++;
    if (nbeats !== 2 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1100 || b_wd[0] !== 32'hCCDD0000) begin
      tests_failed++;
      $display("FAIL split_sw_beat1: beats=%0d addr=%h be=%b wd=%h expected 00000100 1100 ccdd0000",
               nbeats, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if (b_addr[1] !== 32'h104 || b_be[1] !== 4'b0011 || b_wd[1] !== 32'h0000AABB) begin
      tests_failed++;
      $display("FAIL split_sw_beat2: addr=%h be=%b wd=%h expected 00000104 0011 0000aabb",
               b_addr[1], b_be[1], b_wd[1]);
    end
    tests_run++;
    if (busy !== 3 || ld !== 32'h80FF1234) begin
      tests_failed++;
      $display("FAIL split_sw_busy_hold: busy=%0d ld=%h expected 3 and 80ff1234", busy, ld);
    end
    // Read the stored bytes back through a split word load.
    run_access(4'b1010, 3'b000, 32'h102, 32'h0, busy, ld);
    tests_run++;
    if (ld !== 32'hAABBCCDD || busy !== 3 || nbeats !== 2) begin
      tests_failed++;
      $display("FAIL split_lw_readback: got %h busy %0d beats %0d expected aabbccdd busy 3 beats 2",
               ld, busy, nbeats);
    end
  endtask

  task automatic test_load_priority();
    int busy; logic [31:0] ld;
    run_access(4'b1010, 3'b110, 32'h100, 32'h55555555, busy, ld);
    tests_run++;
    if (nbeats !== 1 || b_we[0] !== 1'b0 || ld !== 32'hCCDDBEEF) begin
      tests_failed++;
      $display("FAIL load_priority: beats=%0d we=%b ld=%h expected 1 read beat ld ccddbeef",
               nbeats, b_we[0], ld);
    end
  endtask

  task automatic test_split_lh_wait();
    int busy; logic [31:0] ld;
    mem[32'h0FFFFFFC] = 32'h80123456;
    mem[32'h10000000] = 32'h9ABCDE7F;
    wait_cycles = 2;
    run_access(4'b1001, 3'b000, 32'h0FFFFFFF, 32'h0, busy, ld);
    wait_cycles = 0;
    tests_run++;
    if (ld !== 32'h00007F80) begin
      tests_failed++; $display("FAIL split_lh_data: got %h expected 00007f80", ld);
    end
    tests_run++;
    if (busy !== 7) begin
      tests_failed++; $display("FAIL split_lh_busy: got %0d expected 7", busy);
    end
    tests_run++;
    if (nbeats !== 2 || b_addr[0] !== 32'h0FFFFFFC || b_addr[1] !== 32'h10000000) begin
      tests_failed++;
      $display("FAIL split_lh_addrs: beats=%0d a0=%h a1=%h expected 0ffffffc 10000000",
               nbeats, b_addr[0], b_addr[1]);
    end
  endtask

  task automatic test_addr_wrap();
    int busy; logic [31:0] ld;
    run_access(4'b0000, 3'b110, 32'hFFFFFFFE, 32'h11223344, busy, ld);
    tests_run++;
    if (nbeats !== 2 || b_addr[0] !== 32'hFFFFFFFC || b_be[0] !== 4'b1100 || b_wd[0] !== 32'h33440000) begin
      tests_failed++;
      $display("FAIL wrap_beat1: beats=%0d addr=%h be=%b wd=%h expected fffffffc 1100 33440000",
               nbeats, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if (b_addr[1] !== 32'h00000000 || b_be[1] !== 4'b0011 || b_wd[1] !== 32'h00001122) begin
      tests_failed++;
      $display("FAIL wrap_beat2: addr=%h be=%b wd=%h expected 00000000 0011 00001122",
               b_addr[1], b_be[1], b_wd[1]);
    end
  endtask

  task automatic test_reset_midbeat();
    int busy; logic [31:0] ld;
    hold_ready = 1'b1;
    @(negedge clk);
    mem_read = 4'b1010;
    address  = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus_read !== 1'b1 || bus_addr !== 32'h100 || busywait !== 1'b1) begin
      tests_failed++;
      $display("FAIL midbeat_pending: rd=%b addr=%h busy=%b expected 1 00000100 1",
               bus_read, bus_addr, busywait);
    end
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if ({bus_read, bus_write, bus_addr, bus_byteen, bus_writedata, load_data} !== '0) begin
      tests_failed++;
      $display("FAIL midbeat_reset_outputs: rd=%b wr=%b addr=%h be=%b wd=%h ld=%h expected all zero",
               bus_read, bus_write, bus_addr, bus_byteen, bus_writedata, load_data);
    end
    tests_run++;
    if (busywait !== 1'b1) begin
      tests_failed++; $display("FAIL midbeat_idle_busy: got %b expected 1", busywait);
    end
    mem_read = 4'b0;
    @(negedge clk);
    reset      = 1'b1;
    hold_ready = 1'b0;
    run_access(4'b1010, 3'b000, 32'h200, 32'h0, busy, ld);
    tests_run++;
    if (ld !== 32'h80FF1234 || busy !== 2 || nbeats !== 1) begin
      tests_failed++;
      $display("FAIL after_reset_lw: got %h busy %0d beats %0d expected 80ff1234 busy 2 beats 1",
               ld, busy, nbeats);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_byte_half_loads();
    test_small_stores();
    test_split_sw();
    test_load_priority();
    test_split_lh_wait();
    test_addr_wrap();
    test_reset_midbeat();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
